// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit adder/subtractor split into STAGES ripple sections,
// one section per pipeline stage, with valid/ready handshakes on both sides.
//
// Parameters:
//   WIDTH   operand/result width (>= 1)
//   STAGES  pipeline depth and ripple section count; 1 <= STAGES <= WIDTH,
//           WIDTH must be a multiple of STAGES. Section width CW = WIDTH/STAGES.
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        synchronous active-high reset; clears every stage
//   in_valid   a, b, cin, sub valid this cycle
//   in_ready   block accepts an input this cycle (low while rst is high)
//   a, b       operands
//   cin        carry in (add) / borrow in (subtract)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  sum, cout, ovf valid this cycle
//   out_ready  downstream accepts the output this cycle
//   sum        result modulo 2^WIDTH
//   cout       raw carry out of the top section (subtract: 1 = no borrow)
//   ovf        two's-complement overflow of the result
//
// Each stage register holds the full operand words so that the next section can
// pick its slice with a fixed offset; bits of a/b below the active section are
// never consumed downstream, and only the MSBs survive to the last stage for ovf.

module pipelined_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW   = WIDTH / STAGES;
  localparam int unsigned Last = STAGES - 1;

  // Operand conditioning: subtraction is a + ~b + ~cin.
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? ~cin : cin;

  // Stage registers.
  logic [WIDTH-1:0]  a_q   [STAGES];
  logic [WIDTH-1:0]  b_q   [STAGES];
  logic [WIDTH-1:0]  sum_q [STAGES];
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] v_q;

  // Upstream view of each stage: the primary inputs for stage 0, otherwise the
  // registers of the previous stage.
  logic [WIDTH-1:0]  src_a   [STAGES];
  logic [WIDTH-1:0]  src_b   [STAGES];
  logic [WIDTH-1:0]  src_sum [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;

  // Per-stage next values.
  logic [CW:0]       sec     [STAGES];
  logic [WIDTH-1:0]  sum_d   [STAGES];
  logic [STAGES-1:0] c_d;

  logic [STAGES-1:0] rdy;

  // ---------------------------------------------------------------------------
  // Handshake: a stage may load when it is empty or everything downstream of it
  // can move. The chain is evaluated from the output side back to the input.
  // ---------------------------------------------------------------------------
  always_comb begin
    rdy = '0;
    rdy[Last] = !v_q[Last] || out_ready;
    for (int k = int'(STAGES) - 2; k >= 0; k--) begin
      rdy[k] = !v_q[k] || rdy[k+1];
    end
  end

  assign in_ready = rdy[0] && !rst;

  // ---------------------------------------------------------------------------
  // Section datapath.
  // ---------------------------------------------------------------------------
  always_comb begin
    src_a[0]   = a;
    src_b[0]   = b_eff;
    src_sum[0] = '0;
    src_c      = '0;
    src_v      = '0;
    src_c[0]   = c0;
    src_v[0]   = in_valid;
    for (int k = 1; k < int'(STAGES); k++) begin
      src_a[k]   = a_q[k-1];
      src_b[k]   = b_q[k-1];
      src_sum[k] = sum_q[k-1];
      src_c[k]   = c_q[k-1];
      src_v[k]   = v_q[k-1];
    end

    c_d = '0;
    for (int k = 0; k < int'(STAGES); k++) begin
      sec[k] = {1'b0, src_a[k][k*CW +: CW]}
             + {1'b0, src_b[k][k*CW +: CW]}
             + {{CW{1'b0}}, src_c[k]};
      // Completed lower sections pass through; this section's bits are inserted.
      sum_d[k]                = src_sum[k];
      sum_d[k][k*CW +: CW]    = sec[k][CW-1:0];
      c_d[k]                  = sec[k][CW];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage registers. A stage that is not ready holds its contents, which keeps
  // the output stable under backpressure.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(STAGES); k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
      c_q <= '0;
      v_q <= '0;
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (rdy[k]) begin
          v_q[k]   <= src_v[k];
          a_q[k]   <= src_a[k];
          b_q[k]   <= src_b[k];
          sum_q[k] <= sum_d[k];
          c_q[k]   <= c_d[k];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs straight from the last stage.
  // ---------------------------------------------------------------------------
  assign out_valid = v_q[Last];
  assign sum       = sum_q[Last];
  assign cout      = c_q[Last];
  assign ovf       = (a_q[Last][WIDTH-1] == b_q[Last][WIDTH-1]) &&
                     (sum_q[Last][WIDTH-1] != a_q[Last][WIDTH-1]);

  // Lower operand bits reach the last stage but only the MSBs are used there.
  if (WIDTH > 1) begin : g_unused
    logic unused_low;
    assign unused_low = ^{a_q[Last][WIDTH-2:0], b_q[Last][WIDTH-2:0]};
  end

endmodule

// File: tb/tb_pipelined_adder.sv
module tb_pipelined_adder;

  logic        clk, rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic        cin, sub, cout, ovf;
  logic [15:0] a, b, sum;

  logic        sm_valid, sm_cin, sm_sub;
  logic [3:0]  sm_a, sm_b;
  logic        s2_in_ready, s2_out_valid, s2_cout, s2_ovf;
  logic [3:0]  s2_sum;
  logic        s1_in_ready, s1_out_valid, s1_cout, s1_ovf;
  logic [3:0]  s1_sum;

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int drop_at = -1;

  logic [17:0] exp_q[$];
  logic [17:0] s2_q[$];
  logic [17:0] s1_q[$];

  pipelined_adder #(.WIDTH(16), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  pipelined_adder #(.WIDTH(4), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .in_valid(sm_valid), .in_ready(s2_in_ready),
    .a(sm_a), .b(sm_b), .cin(sm_cin), .sub(sm_sub), .out_valid(s2_out_valid),
    .out_ready(1'b1), .sum(s2_sum), .cout(s2_cout), .ovf(s2_ovf)
  );

  pipelined_adder #(.WIDTH(4), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .in_valid(sm_valid), .in_ready(s1_in_ready),
    .a(sm_a), .b(sm_b), .cin(sm_cin), .sub(sm_sub), .out_valid(s1_out_valid),
    .out_ready(1'b1), .sum(s1_sum), .cout(s1_cout), .ovf(s1_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer arithmetic on the unsigned and signed readings of
  // the operands. Returns {ovf, cout, sum zero-extended to 16 bits}.
  function automatic logic [17:0] model(input int w, input logic [15:0] va, vb,
                                        input logic vc, vs);
    longint m, half, ua, ub, sa, sb, full, sres;
    logic co, ov;
    m    = longint'(1) << w;
    half = m / 2;
    ua   = longint'(va);
    ub   = longint'(vb);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    if (vs) begin
      full = ua - ub - longint'(vc);
      sres = sa - sb - longint'(vc);
      co   = (full >= 0);
    end else begin
      full = ua + ub + longint'(vc);
      sres = sa + sb + longint'(vc);
      co   = (full >= m);
    end
    ov = (sres >= half) || (sres < -half);
    return {ov, co, 16'(full & (m - 1))};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Main scoreboard monitor: sampled mid-cycle, reflecting what the next edge does.
  initial begin
    logic        stall_prev;
    logic [18:0] prev_out;
    logic [17:0] e;
    stall_prev = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        stall_prev = 1'b0;
      end else begin
        if (stall_prev) chk("hold_stable", 32'({out_valid, ovf, cout, sum}), 32'(prev_out));
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_out", 32'({ovf, cout, sum}), 32'h3ffff);
          end else begin
            e = exp_q.pop_front();
            chk("w16_result", 32'({ovf, cout, sum}), 32'(e));
          end
        end
        if (in_valid && in_ready) exp_q.push_back(model(16, a, b, cin, sub));
        stall_prev = out_valid && !out_ready;
        prev_out   = {out_valid, ovf, cout, sum};
      end
    end
  end

  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        s2_q.delete();
        s1_q.delete();
      end else begin
        if (s2_out_valid) begin
          if (s2_q.size() == 0) chk("s2_unexpected", 32'(s2_sum), 32'hffff);
          else begin
            e = s2_q.pop_front();
            chk("w4s2_result", 32'({s2_ovf, s2_cout, 12'b0, s2_sum}), 32'(e));
          end
        end
        if (s1_out_valid) begin
          if (s1_q.size() == 0) chk("s1_unexpected", 32'(s1_sum), 32'hffff);
          else begin
            e = s1_q.pop_front();
            chk("w4s1_result", 32'({s1_ovf, s1_cout, 12'b0, s1_sum}), 32'(e));
          end
        end
        if (sm_valid && s2_in_ready) s2_q.push_back(model(4, {12'b0, sm_a}, {12'b0, sm_b},
                                                          sm_cin, sm_sub));
        if (sm_valid && s1_in_ready) s1_q.push_back(model(4, {12'b0, sm_a}, {12'b0, sm_b},
                                                          sm_cin, sm_sub));
      end
    end
  end

  // Present one input and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [15:0] va, vb, input logic vc, vs);
    logic ok;
    ok = 1'b0;
    a = va; b = vb; cin = vc; sub = vs; in_valid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      if (drop_at < 0) drop_at = acc_cnt;
    end
    if (!ok) chk("send_timeout", 32'(ok), 32'(1));
    acc_cnt++;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && s2_q.size() == 0 && s1_q.size() == 0) break;
    end
    chk(name, exp_q.size() + s2_q.size() + s1_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  logic [15:0] d_a   [5] = '{16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005, 16'h8000};
  logic [15:0] d_b   [5] = '{16'h0FFF, 16'h0000, 16'h0001, 16'h0007, 16'h0001};
  logic        d_cin [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        d_sub [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  logic [17:0] d_exp [5] = '{{2'b00, 16'h2234}, {2'b01, 16'h0000}, {2'b10, 16'h8000},
                             {2'b00, 16'hFFFE}, {2'b11, 16'h7FFF}};

  initial begin
    int   lat;
    logic drain_ok, ghost, ok, rand_done;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    sm_valid = 1'b0; sm_a = '0; sm_b = '0; sm_cin = 1'b0; sm_sub = 1'b0;

    // Reset state.
    @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_outputs", 32'({ovf, cout, sum}), 0);
    chk("rst_small_valid", 32'({s2_out_valid, s1_out_valid}), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1;

    // Directed vectors with latency measurement.
    for (int i = 0; i < 5; i++) begin
      send(d_a[i], d_b[i], d_cin[i], d_sub[i]);
      lat = 0;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        if (out_valid) begin
          lat = n;
          break;
        end
      end
      chk("dir_latency", lat, 4);
      chk("dir_value", 32'({ovf, cout, sum}), 32'(d_exp[i]));
      @(posedge clk);
      #1;
    end
    wait_empty("dir_drain");

    // Backpressure: 8 back-to-back inputs, out_ready low for 6 cycles.
    acc_cnt = 0;
    drop_at = -1;
    drain_ok = 1'b1;
    fork
      begin
        for (int i = 0; i < 8; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      begin
        out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
          @(negedge clk);
          if (!out_valid) drain_ok = 1'b0;
        end
      end
    join
    chk("bp_drop_after", drop_at, 4);
    chk("bp_drain_contig", 32'(drain_ok), 1);
    wait_empty("bp_drain");

    // Reset with three results in flight.
    for (int i = 0; i < 3; i++) send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_sum", 32'(sum), 0);
    ghost = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (out_valid) ghost = 1'b1;
    end
    chk("mid_rst_no_ghost", 32'(ghost), 0);
    @(posedge clk);
    #1;
    send(16'h4321, 16'h1111, 1'b0, 1'b1);
    wait_empty("mid_rst_new");

    // Random traffic with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_empty("rand_drain");

    // Exhaustive W=4 with STAGES=2 and STAGES=1.
    for (int v = 0; v < 1024; v++) begin
      sm_a = 4'(v); sm_b = 4'(v >> 4); sm_cin = v[8]; sm_sub = v[9]; sm_valid = 1'b1;
      ok = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (s2_in_ready && s1_in_ready) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) chk("sm_accept", 32'(ok), 1);
      @(posedge clk);
      #1;
    end
    sm_valid = 1'b0;
    wait_empty("sm_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined WIDTH-bit adder/subtractor built from chained ripple sections, one section per pipeline stage, with a valid/ready handshake on both sides. It is the multi-bit, registered successor to the single-bit full adder in the adders library. It sits in datapaths that need a wide add at high clock rate and can tolerate STAGES cycles of latency, with full backpressure support.

## Interface
- WIDTH, 16, operand and result width in bits; must be >= 1.
- STAGES, 4, number of pipeline stages and ripple sections; 1 <= STAGES <= WIDTH, and WIDTH % STAGES == 0. Section width is CW = WIDTH/STAGES.

Ports:
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a, b, cin and sub are valid this cycle.
- in_ready  output  1  block can accept an input this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry in for add; borrow in for subtract.
- sub  input  1  0: a+b+cin; 1: a-b-cin.
- out_valid  output  1  sum, cout and ovf are valid this cycle.
- out_ready  input  1  downstream accepts the output this cycle.
- sum  output  WIDTH  result modulo 2^WIDTH.
- cout  output  1  raw carry out of the MSB section; in subtract mode 1 means no borrow.
- ovf  output  1  two's-complement signed overflow of the result.

## Operation
- Arithmetic: b_eff = sub ? ~b : b and c0 = sub ? ~cin : cin. The result is {cout, sum} = a + b_eff + c0, computed over WIDTH+1 bits. ovf = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]).
- Section k (0..STAGES-1) adds bits [k*CW +: CW] of a and b_eff plus the carry registered by section k-1. Section 0 uses c0.
- Stage k registers:
  - the completed sum bits of sections 0..k;
  - the section-k carry;
  - the a and b_eff bits of the unprocessed upper sections, and a[W-1] and b_eff[W-1] for the ovf computation;
  - a valid bit v[k].
- Handshake:
  - rdy[STAGES-1] = !v[STAGES-1] || out_ready.
  - rdy[k] = !v[k] || rdy[k+1].
  - in_ready = rdy[0] && !rst.
  - Stage k loads from stage k-1, or from the inputs for k = 0, when rdy[k] is high. Its v[k] then takes the upstream valid.
- Accept occurs on a rising edge with in_valid && in_ready. Output transfer occurs on a rising edge with out_valid && out_ready.
- out_valid = v[STAGES-1]. sum, cout and ovf come directly from the last-stage registers.
- Outputs hold stable while out_valid && !out_ready. Inputs presented while in_ready is low are ignored and not captured.
- Results leave in acceptance order. No reordering, drops or duplicates.

## Timing
- Reset, synchronous: at any edge with rst high, all v[k] and all data registers clear. The cycle after that edge shows out_valid=0, sum=0, cout=0, ovf=0. in_ready is 0 while rst is high and 1 in the first cycle after rst falls.
- Reset mid-operation discards every in-flight result. No output for those results appears after reset.
- Latency: an input accepted at edge E, with no stalls, makes out_valid high in the cycle after edge E+STAGES-1. For STAGES=1 this is the cycle directly after E.
- Throughput: one result per cycle while out_ready stays high.
- in_ready has a combinational path from out_ready when the pipeline is full.
- Full pipeline with out_ready low: in_ready=0 and all stages hold.
- Simultaneous events: with a full pipeline, out_ready=1 and in_valid=1 in the same cycle, the edge both emits the oldest result and accepts the new input. No bubble is inserted.
- A bubble in stage k lets the stages upstream of it advance even when out_ready is low.

## Test plan
- W=16, S=4, streaming, out_ready=1: a=0x1234, b=0x0FFF, cin=1, sub=0 -> sum=0x2234, cout=0, ovf=0; out_valid rises exactly 4 cycles after the accept.
- Carry across all sections, W=16, S=4: a=0xFFFF, b=0x0000, cin=1, sub=0 -> sum=0x0000, cout=1, ovf=0. Also a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, ovf=1.
- Subtract: a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0 (borrow), ovf=0. Also a=0x8000, b=0x0001, cin=0, sub=1 -> sum=0x7FFF, ovf=1.
- Backpressure: stream 8 back-to-back inputs with out_ready held 0 for 6 cycles. Required:
  - in_ready drops after 4 accepts;
  - the held output stays stable;
  - all 8 results arrive in order once out_ready=1, one per cycle.
- Reset mid-operation: assert rst for 1 cycle while 3 results are in flight -> the next cycle shows out_valid=0 and sum=0; none of the 3 ever emerges; a new input completes normally.
- Exhaustive check at W=4, S=2 and W=4, S=1: all a, b, cin and sub combinations (1024 vectors) -> each {cout, sum} and ovf matches the reference model.
